axi_wdata_trace_capture: RTL and testbench
==========================================

Name: axi_wdata_trace_capture

Overview:
- Synthesizable, multi-channel successor to the testbench W-channel result dump.
- Snoops NrChannels AXI W channels (one per Ara cluster) and captures every handshaken beat with a nonzero strobe into a per-channel FIFO.
- Captures only inside a software trigger window, i.e. between the ctrl-register event-trigger values ON and OFF.
- A round-robin arbiter drains the FIFOs to a single valid/ready trace port for a DMA/UART drainer or a bench scoreboard.

Parameters:
- NrChannels, 4, number of snooped W channels (clusters).
- DataWidth, 128, W data width per channel in bits; multiple of 8.
- FifoDepth, 8, entries per channel FIFO; power of two, >= 2.
- CntWidth, 32, width of the beat, byte and drop counters.
- TrigOn, 64'h1, trigger_i value that opens the window.
- TrigOff, 64'hFFFF_FFFF_FFFF_FFFF, trigger_i value that closes the window.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- trigger_i  in  64  event-trigger register value
- dump_en_i  in  1  capture qualifier (hw counter enable)
- w_data_i  in  NrChannels*DataWidth  snooped W data, channel c at [c*DataWidth +: DataWidth]
- w_strb_i  in  NrChannels*DataWidth/8  snooped W strobes
- w_valid_i  in  NrChannels  snooped w_valid
- w_ready_i  in  NrChannels  snooped w_ready
- out_valid_o  out  1  trace beat valid
- out_ready_i  in  1  trace beat accepted
- out_chan_o  out  $clog2(NrChannels) (min 1)  source channel
- out_data_o  out  DataWidth  captured data
- out_strb_o  out  DataWidth/8  captured strobe
- state_o  out  2  FSM state encoding
- done_o  out  1  one-cycle pulse when the drain completes
- overflow_o  out  1  sticky: at least one beat dropped
- beat_cnt_o  out  CntWidth  beats enqueued
- byte_cnt_o  out  CntWidth  sum of strobe popcounts of enqueued beats
- drop_cnt_o  out  CntWidth  beats dropped

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge):
  - state IDLE; all FIFOs empty; RR pointer 0.
  - All counters 0; overflow_o=0; done_o=0; out_valid_o=0.
  - Data outputs are don't-care while out_valid_o=0.
  - Reset mid-operation discards buffered and in-flight beats with no partial output.
- FSM states: IDLE=0, CAPTURE=1, DRAIN=2, DONE=3.
  - IDLE -> CAPTURE when trigger_i==TrigOn.
  - CAPTURE -> DRAIN when trigger_i==TrigOff.
  - DRAIN -> DONE when all FIFOs are empty and no enqueue is occurring this cycle; done_o=1 for exactly that transition cycle.
  - DONE -> CAPTURE when trigger_i==TrigOn. Entering CAPTURE from DONE clears all counters and overflow_o in the same edge.
  - TrigOn while in CAPTURE/DRAIN is ignored. TrigOff while in IDLE/DONE is ignored. All other trigger values are ignored.
- Capture condition, channel c, cycle N: state==CAPTURE && dump_en_i && w_valid_i[c] && w_ready_i[c] && |strb_c.
  - Capture is evaluated on the state before any transition in cycle N; a TrigOff cycle still captures.
  - If FIFO c is not full: enqueue {data, strb}; beat_cnt += 1; byte_cnt += popcount(strb_c).
  - If FIFO c is full: drop the beat; drop_cnt += 1; overflow_o=1.
  - Enqueues from several channels in one cycle are summed into the counters in the same cycle.
  - All counters saturate at 2^CntWidth-1.
- Same-cycle pop and push on a full FIFO: the push is accepted (pop frees the slot first).
- Latency: a beat captured in cycle N is visible on out_valid_o no earlier than N+1 (registered FIFO head).
- Output arbitration:
  - Round-robin over non-empty FIFOs, starting at the RR pointer.
  - On out_valid_o && out_ready_i: pop the granted FIFO; pointer = granted+1 mod NrChannels.
  - While out_valid_o && !out_ready_i: out_chan_o/out_data_o/out_strb_o are stable and the grant is locked.
  - Draining is active in every state, including IDLE and DONE.
- Beats are emitted in enqueue order within a channel; no ordering guarantee across channels.

Decomposition:
- Package axi_wdata_trace_pkg:
  - trace_state_e (IDLE/CAPTURE/DRAIN/DONE)
  - default TrigOn/TrigOff constants
  - popcount function
- Sub-module trace_fifo: a single parametrised sync FIFO (DataWidth+DataWidth/8 bits wide, FifoDepth deep, full/empty, simultaneous push/pop), instantiated NrChannels times.
- RR arbiter, FSM and counters live in the top module.

Test Plan:
- Window gating: 3 beats on ch0 (strb all-ones) before TrigOn, then TrigOn, 3 beats, TrigOff, 2 beats -> exactly 3 beats out; beat_cnt=3; byte_cnt=48; done_o pulses once; state ends DONE.
- Strobe and qualifier filter: in CAPTURE, ch1 beats with strb=0, then dump_en_i=0 with strb=FFFF, then strb=000F -> 1 beat out (strb 000F); byte_cnt=4.
- Concurrency/RR: all 4 channels handshake the same cycle for 2 cycles, out_ready_i=1 -> 8 beats out, out_chan_o sequence 0,1,2,3,0,1,2,3; beat_cnt=8.
- Overflow: out_ready_i=0, 10 beats on ch2 with FifoDepth=8 -> drop_cnt=2; overflow_o=1. Release ready -> first 8 beats in order. Re-arm from DONE clears drop_cnt and overflow_o.
- Backpressure stability: toggle out_ready_i 0/1 each cycle -> out_chan/data/strb unchanged whenever the previous cycle had valid && !ready.
- Mid-run reset: assert rst_i with 5 beats buffered in CAPTURE -> next cycle out_valid_o=0, state_o=0, all counters 0; TrigOff afterwards is ignored.

Source files
------------

// File: rtl/axi_wdata_trace_pkg.sv
// Shared types and helpers for the AXI W-channel trace capture block.
package axi_wdata_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } trace_state_e;

  localparam logic [63:0] TRIG_ON_DEFAULT  = 64'h1;
  localparam logic [63:0] TRIG_OFF_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

  // Widest strobe the popcount helper accepts (DataWidth up to 1024 bits).
  localparam int unsigned MAX_STRB_BITS = 128;
  localparam int unsigned POPCNT_W      = $clog2(MAX_STRB_BITS + 1);

  function automatic logic [POPCNT_W-1:0] popcount(input logic [MAX_STRB_BITS-1:0] v);
    logic [POPCNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_STRB_BITS; i++) begin
      cnt = cnt + POPCNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/axi_wdata_trace_capture_fifo.sv
// Single-clock FIFO holding captured {strb, data} beats for one snooped channel.
module trace_fifo #(
  parameter int unsigned Width = 144,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  // A pop frees the slot first, so a full FIFO still accepts a same-cycle push.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count_q/pointers gate every read, so stale words are never visible.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/axi_wdata_trace_capture.sv
// Snoops NrChannels AXI W channels inside a trigger window and drains captured beats round-robin.
module axi_wdata_trace_capture
  import axi_wdata_trace_pkg::*;
#(
  parameter int unsigned NrChannels = 4,
  parameter int unsigned DataWidth  = 128,
  parameter int unsigned FifoDepth  = 8,
  parameter int unsigned CntWidth   = 32,
  parameter logic [63:0] TrigOn     = TRIG_ON_DEFAULT,
  parameter logic [63:0] TrigOff    = TRIG_OFF_DEFAULT,
  localparam int unsigned StrbW     = DataWidth / 8,
  localparam int unsigned ChanW     = (NrChannels > 1) ? $clog2(NrChannels) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [63:0]                   trigger_i,
  input  logic                          dump_en_i,
  input  logic [NrChannels*DataWidth-1:0] w_data_i,
  input  logic [NrChannels*StrbW-1:0]   w_strb_i,
  input  logic [NrChannels-1:0]         w_valid_i,
  input  logic [NrChannels-1:0]         w_ready_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [ChanW-1:0]              out_chan_o,
  output logic [DataWidth-1:0]          out_data_o,
  output logic [StrbW-1:0]              out_strb_o,
  output logic [1:0]                    state_o,
  output logic                          done_o,
  output logic                          overflow_o,
  output logic [CntWidth-1:0]           beat_cnt_o,
  output logic [CntWidth-1:0]           byte_cnt_o,
  output logic [CntWidth-1:0]           drop_cnt_o
);

  localparam int unsigned FifoW = DataWidth + StrbW;

  trace_state_e state_q, state_d;
  logic         clear_cnt;

  logic [NrChannels-1:0] full, empty, cap, push, pop, drop;
  logic [FifoW-1:0]      fifo_dout [NrChannels];

  logic [ChanW-1:0] rr_ptr_q, grant_q, grant;
  logic             lock_q, found;
  int unsigned      idx;

  logic [CntWidth-1:0] beat_q, byte_q, drop_q;
  logic [CntWidth-1:0] beat_inc, byte_inc, drop_inc;
  logic                overflow_q;

  function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] a,
                                                 input logic [CntWidth-1:0] b);
    logic [CntWidth:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CntWidth] ? '1 : s[CntWidth-1:0];
  endfunction

  for (genvar c = 0; c < NrChannels; c++) begin : g_fifo
    trace_fifo #(
      .Width (FifoW),
      .Depth (FifoDepth)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push[c]),
      .pop_i   (pop[c]),
      .data_i  ({w_strb_i[c*StrbW +: StrbW], w_data_i[c*DataWidth +: DataWidth]}),
      .data_o  (fifo_dout[c]),
      .full_o  (full[c]),
      .empty_o (empty[c])
    );
  end

  // A stalled beat keeps its grant so the presented channel/data cannot change under backpressure.
  // NOTE: every always_comb output gets a default first, otherwise unassigned paths infer latches.
  always_comb begin
    grant = grant_q;
    found = 1'b0;
    idx   = 0;
    if (!lock_q) begin
      for (int unsigned i = 0; i < NrChannels; i++) begin
        idx = (int'(rr_ptr_q) + i) % NrChannels;
        if (!found && !empty[idx]) begin
          grant = ChanW'(idx);
          found = 1'b1;
        end
      end
    end
  end

  assign out_valid_o              = |(~empty);
  assign out_chan_o               = grant;
  assign {out_strb_o, out_data_o} = fifo_dout[grant];

  always_comb begin
    cap      = '0;
    push     = '0;
    drop     = '0;
    pop      = '0;
    beat_inc = '0;
    byte_inc = '0;
    drop_inc = '0;
    for (int c = 0; c < NrChannels; c++) begin
      cap[c]  = (state_q == CAPTURE) && dump_en_i && w_valid_i[c] && w_ready_i[c] &&
                (|w_strb_i[c*StrbW +: StrbW]);
      pop[c]  = out_valid_o && out_ready_i && (grant == ChanW'(c));
      push[c] = cap[c] && (!full[c] || pop[c]);
      drop[c] = cap[c] && full[c] && !pop[c];
      if (push[c]) begin
        beat_inc = beat_inc + CntWidth'(1);
        byte_inc = byte_inc + CntWidth'(popcount(MAX_STRB_BITS'(w_strb_i[c*StrbW +: StrbW])));
      end
      if (drop[c]) drop_inc = drop_inc + CntWidth'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    done_o    = 1'b0;
    clear_cnt = 1'b0;
    case (state_q)
      IDLE:    if (trigger_i == TrigOn) state_d = CAPTURE;
      CAPTURE: if (trigger_i == TrigOff) state_d = DRAIN;
      DRAIN: begin
        if ((&empty) && !(|push)) begin
          state_d = DONE;
          done_o  = 1'b1;
        end
      end
      DONE: begin
        if (trigger_i == TrigOn) begin
          state_d   = CAPTURE;
          clear_cnt = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      lock_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant;
      lock_q  <= out_valid_o && !out_ready_i;
      if (out_valid_o && out_ready_i) begin
        rr_ptr_q <= (grant == ChanW'(NrChannels - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_cnt) begin
      beat_q     <= '0;
      byte_q     <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      beat_q     <= sat_add(beat_q, beat_inc);
      byte_q     <= sat_add(byte_q, byte_inc);
      drop_q     <= sat_add(drop_q, drop_inc);
      overflow_q <= overflow_q | (|drop);
    end
  end

  assign state_o    = state_q;
  assign overflow_o = overflow_q;
  assign beat_cnt_o = beat_q;
  assign byte_cnt_o = byte_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_axi_wdata_trace_capture.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_axi_wdata_trace_capture;
  import axi_wdata_trace_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 128;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 8;
  localparam int CW    = 32;
  localparam logic [63:0] ON  = 64'h1;
  localparam logic [63:0] OFF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam longint MAXC = longint'(32'hFFFF_FFFF);

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic [63:0]     trigger_i = '0;
  logic            dump_en_i = 1'b0;
  logic [N*DW-1:0] w_data_i = '0;
  logic [N*SW-1:0] w_strb_i = '0;
  logic [N-1:0]    w_valid_i = '0;
  logic [N-1:0]    w_ready_i = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [1:0]      out_chan_o;
  logic [DW-1:0]   out_data_o;
  logic [SW-1:0]   out_strb_o;
  logic [1:0]      state_o;
  logic            done_o;
  logic            overflow_o;
  logic [CW-1:0]   beat_cnt_o, byte_cnt_o, drop_cnt_o;

  always #5 clk = ~clk;

  axi_wdata_trace_capture #(
    .NrChannels (N),
    .DataWidth  (DW),
    .FifoDepth  (DEPTH),
    .CntWidth   (CW),
    .TrigOn     (ON),
    .TrigOff    (OFF)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .trigger_i   (trigger_i),
    .dump_en_i   (dump_en_i),
    .w_data_i    (w_data_i),
    .w_strb_i    (w_strb_i),
    .w_valid_i   (w_valid_i),
    .w_ready_i   (w_ready_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_chan_o  (out_chan_o),
    .out_data_o  (out_data_o),
    .out_strb_o  (out_strb_o),
    .state_o     (state_o),
    .done_o      (done_o),
    .overflow_o  (overflow_o),
    .beat_cnt_o  (beat_cnt_o),
    .byte_cnt_o  (byte_cnt_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } beat_t;

  beat_t  mq [N][$];
  int     m_state = 0;
  longint m_beat = 0, m_byte = 0, m_drop = 0;
  bit     m_ovf = 0, m_live = 0, m_held = 0;
  int     m_ptr = 0, m_held_ch = 0;

  bit            prev_stall = 0;
  logic [1:0]    prev_chan;
  logic [DW-1:0] prev_data;
  logic [SW-1:0] prev_strb;

  int            log_chan [$];
  logic [DW-1:0] log_data [$];
  logic [SW-1:0] log_strb [$];
  int            done_pulses = 0;

  function automatic longint sat(input longint v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  always @(negedge clk) begin
    bit all_empty;
    bit exp_valid;
    int g;
    logic [SW-1:0] s;
    all_empty = 1;
    for (int c = 0; c < N; c++) if (mq[c].size() > 0) all_empty = 0;
    exp_valid = !all_empty;
    g = -1;
    if (exp_valid) begin
      if (m_held) g = m_held_ch;
      else for (int i = 0; i < N; i++) if (g < 0 && mq[(m_ptr + i) % N].size() > 0) g = (m_ptr + i) % N;
    end

    if (m_live) begin
      check("out_valid", out_valid_o, exp_valid);
      if (exp_valid) begin
        check("out_chan", out_chan_o, g);
        check("out_data", out_data_o, mq[g][0].data);
        check("out_strb", out_strb_o, mq[g][0].strb);
      end
      check("state", state_o, m_state);
      check("done", done_o, (m_state == 2) && all_empty);
      check("overflow", overflow_o, m_ovf);
      check("beat_cnt", beat_cnt_o, m_beat);
      check("byte_cnt", byte_cnt_o, m_byte);
      check("drop_cnt", drop_cnt_o, m_drop);
      if (prev_stall) begin
        check("stall_chan", out_chan_o, prev_chan);
        check("stall_data", out_data_o, prev_data);
        check("stall_strb", out_strb_o, prev_strb);
      end
    end

    if (out_valid_o === 1'b1 && out_ready_i) begin
      log_chan.push_back(int'(out_chan_o));
      log_data.push_back(out_data_o);
      log_strb.push_back(out_strb_o);
    end
    if (done_o === 1'b1) done_pulses++;
    prev_stall = (out_valid_o === 1'b1) && !out_ready_i;
    prev_chan  = out_chan_o;
    prev_data  = out_data_o;
    prev_strb  = out_strb_o;

    if (rst_i) begin
      for (int c = 0; c < N; c++) mq[c].delete();
      m_state = 0; m_beat = 0; m_byte = 0; m_drop = 0;
      m_ovf = 0; m_ptr = 0; m_held = 0; m_live = 1;
      prev_stall = 0;
    end else if (m_live) begin
      if (exp_valid && out_ready_i) begin
        void'(mq[g].pop_front());
        m_ptr  = (g + 1) % N;
        m_held = 0;
      end else if (exp_valid) begin
        m_held = 1; m_held_ch = g;
      end else begin
        m_held = 0;
      end
      if (m_state == 1 && dump_en_i) begin
        for (int c = 0; c < N; c++) begin
          s = w_strb_i[c*SW +: SW];
          if (w_valid_i[c] && w_ready_i[c] && s != '0) begin
            if (mq[c].size() < DEPTH) begin
              mq[c].push_back('{data: w_data_i[c*DW +: DW], strb: s});
              m_beat = sat(m_beat + 1);
              m_byte = sat(m_byte + $countones(s));
            end else begin
              m_drop = sat(m_drop + 1);
              m_ovf  = 1;
            end
          end
        end
      end
      case (m_state)
        0: if (trigger_i == ON) m_state = 1;
        1: if (trigger_i == OFF) m_state = 2;
        2: if (all_empty) m_state = 3;
        default: if (trigger_i == ON) begin
          m_state = 1; m_beat = 0; m_byte = 0; m_drop = 0; m_ovf = 0;
        end
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_w();
    w_valid_i = '0; w_ready_i = '0; w_strb_i = '0; w_data_i = '0;
  endtask

  task automatic beat(input int ch, input logic [DW-1:0] d, input logic [SW-1:0] s);
    clear_w();
    w_valid_i[ch] = 1'b1;
    w_ready_i[ch] = 1'b1;
    w_data_i[ch*DW +: DW] = d;
    w_strb_i[ch*SW +: SW] = s;
    tick();
    clear_w();
  endtask

  task automatic trig(input logic [63:0] v);
    trigger_i = v;
    tick();
    trigger_i = '0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200 && state_o != 2'd3; i++) tick();
    check(name, state_o, 2'd3);
  endtask

  task automatic clear_log();
    log_chan.delete(); log_data.delete(); log_strb.delete();
    done_pulses = 0;
  endtask

  initial begin
    repeat (2) tick();
    rst_i = 1'b0;
    check("rst_state", state_o, 2'd0);
    check("rst_valid", out_valid_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_ovf", overflow_o, 1'b0);
    check("rst_cnts", {beat_cnt_o, byte_cnt_o, drop_cnt_o}, '0);

    // Window gating
    dump_en_i = 1'b1; out_ready_i = 1'b1;
    clear_log();
    for (int i = 0; i < 3; i++) beat(0, 128'h10 + i, '1);
    trig(ON);
    for (int i = 0; i < 3; i++) beat(0, 128'hA0 + i, '1);
    trig(OFF);
    for (int i = 0; i < 2; i++) beat(0, 128'hB0 + i, '1);
    wait_done("win_state_done");
    tick();
    check("win_out_beats", log_chan.size(), 3);
    if (log_data.size() > 0) check("win_first_data", log_data[0], 128'hA0);
    check("win_beat_cnt", beat_cnt_o, 3);
    check("win_byte_cnt", byte_cnt_o, 48);
    check("win_done_pulses", done_pulses, 1);

    // Strobe and qualifier filter
    trig(ON);
    clear_log();
    beat(1, 128'h1, '0);
    beat(1, 128'h2, '0);
    dump_en_i = 1'b0;
    beat(1, 128'h3, 16'hFFFF);
    dump_en_i = 1'b1;
    beat(1, 128'h4, 16'h000F);
    trig(OFF);
    wait_done("flt_state_done");
    check("flt_out_beats", log_chan.size(), 1);
    if (log_strb.size() > 0) check("flt_strb", log_strb[0], 16'h000F);
    if (log_data.size() > 0) check("flt_data", log_data[0], 128'h4);
    check("flt_beat_cnt", beat_cnt_o, 1);
    check("flt_byte_cnt", byte_cnt_o, 4);

    // Concurrency and round-robin order from a freshly reset pointer
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    trig(ON);
    clear_log();
    for (int k = 0; k < 2; k++) begin
      w_valid_i = '1; w_ready_i = '1; w_strb_i = '1;
      for (int c = 0; c < N; c++) w_data_i[c*DW +: DW] = 128'(c * 16 + k);
      tick();
    end
    clear_w();
    repeat (12) tick();
    check("rr_out_beats", log_chan.size(), 8);
    for (int i = 0; i < 8; i++) if (i < log_chan.size()) check($sformatf("rr_chan[%0d]", i), log_chan[i], i % 4);
    check("rr_beat_cnt", beat_cnt_o, 8);
    trig(OFF);
    wait_done("rr_state_done");

    // Overflow on one channel under full backpressure
    trig(ON);
    clear_log();
    out_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) beat(2, 128'(i), '1);
    tick();
    check("ovf_drop_cnt", drop_cnt_o, 2);
    check("ovf_flag", overflow_o, 1'b1);
    check("ovf_beat_cnt", beat_cnt_o, 8);
    out_ready_i = 1'b1;
    repeat (12) tick();
    check("ovf_out_beats", log_data.size(), 8);
    for (int i = 0; i < 8; i++) if (i < log_data.size()) check($sformatf("ovf_data[%0d]", i), log_data[i], 128'(i));
    trig(OFF);
    wait_done("ovf_state_done");
    trig(ON);
    check("rearm_state", state_o, 2'd1);
    check("rearm_drop_cnt", drop_cnt_o, 0);
    check("rearm_ovf", overflow_o, 1'b0);

    // Mid-run reset with beats buffered
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) beat(i % N, 128'hC0 + i, 16'h00FF);
    check("mid_valid_before", out_valid_o, 1'b1);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    check("mid_valid", out_valid_o, 1'b0);
    check("mid_state", state_o, 2'd0);
    check("mid_cnts", {beat_cnt_o, byte_cnt_o, drop_cnt_o}, '0);
    trig(OFF);
    check("mid_trigoff_ignored", state_o, 2'd0);
    check("mid_valid_after", out_valid_o, 1'b0);

    // Randomised traffic; the first stretch toggles out_ready every cycle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r;
      r = $urandom_range(0, 99);
      trigger_i = (r < 5) ? ON : (r < 9) ? OFF : (r < 12) ? 64'($urandom) : 64'h0;
      dump_en_i = ($urandom_range(0, 7) != 0);
      w_valid_i = 4'($urandom); w_ready_i = 4'($urandom) | 4'($urandom);
      for (int k = 0; k < (N * DW) / 32; k++) w_data_i[k*32 +: 32] = $urandom;
      for (int c = 0; c < N; c++)
        w_strb_i[c*SW +: SW] = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      out_ready_i = (cyc < 300) ? cyc[0] : ($urandom_range(0, 9) < 6);
      rst_i = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst_i = 1'b0; trigger_i = '0; clear_w();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
